// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard and a pending-producer count.
// Define REGFILE_SCOREBOARD_BYPASS_EN to forward same-cycle writes to the read ports.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              link,
    input  logic [DATA_W-1:0] link_data,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              stall,
    output logic [ADDR_W:0]   pending
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   pending_q, pending_d;

    logic we_commit, link_commit;
    logic [ADDR_W-1:0] raddr_v [2];
    logic [DATA_W-1:0] rd_v    [2];
    logic              bz_v    [2];

    // A write only commits outside reset, and never to index 0.
    assign we_commit   = we && (waddr != '0) && !rst;
    assign link_commit = link && (LINK_IDX != '0) && !rst;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        busy_d = busy_q;
        if (we_commit)
            busy_d[waddr] = 1'b0;
        if (link_commit)
            busy_d[LINK_IDX] = 1'b0;
        if (issue && (issue_addr != '0))
            busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;

        pending_d = '0;
        for (int i = 0; i < DEPTH; i++)
            pending_d = pending_d + (ADDR_W + 1)'(busy_d[i]);
    end

    // NOTE: the array is reset explicitly because every register must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            // NOTE: non-blocking updates; the later link assignment wins over we on LINK_REG.
            if (we_commit)
                regs_q[waddr] <= wdata;
            if (link_commit)
                regs_q[LINK_IDX] <= link_data;
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign raddr_v[0] = raddr1;
    assign raddr_v[1] = raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_v[p] = (raddr_v[p] == '0) ? '0 : regs_q[raddr_v[p]];
            bz_v[p] = busy_q[raddr_v[p]];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
            if (link_commit && (raddr_v[p] == LINK_IDX)) begin
                rd_v[p] = link_data;
                bz_v[p] = 1'b0;
            end else if (we_commit && (raddr_v[p] == waddr)) begin
                rd_v[p] = wdata;
                bz_v[p] = 1'b0;
            end
`endif
        end
    end

    assign rdata1  = rd_v[0];
    assign rdata2  = rd_v[1];
    assign busy1   = bz_v[0];
    assign busy2   = bz_v[1];
    assign stall   = bz_v[0] | bz_v[1];
    assign pending = pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: array model plus directed vectors.
// Honours REGFILE_SCOREBOARD_BYPASS_EN the same way the design does.
module tb_regfile_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int LINK   = 31;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we = 1'b0, link = 1'b0, issue = 1'b0;
    logic [ADDR_W-1:0] waddr = '0, raddr1 = '0, raddr2 = '0, issue_addr = '0;
    logic [DATA_W-1:0] wdata = '0, link_data = '0;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              busy1, busy2, stall;
    logic [ADDR_W:0]   pending;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: plain arrays updated from the rules, not from RTL structure.
    logic [DATA_W-1:0] m_regs [32];
    logic [31:0]       m_busy;

    regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .link(link), .link_data(link_data), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2), .issue(issue), .issue_addr(issue_addr),
        .busy1(busy1), .busy2(busy2), .stall(stall), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_rdata(input logic [ADDR_W-1:0] r);
        if (r == 0) return '0;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        if (!rst && link && r == LINK) return link_data;
        if (!rst && we && r == waddr) return wdata;
`endif
        return m_regs[r];
    endfunction

    function automatic logic exp_busy(input logic [ADDR_W-1:0] r);
        if (r == 0) return 1'b0;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        if (!rst && link && r == LINK) return 1'b0;
        if (!rst && we && r == waddr) return 1'b0;
`endif
        return m_busy[r];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (we && waddr != 0) begin
                m_regs[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (link) begin
                m_regs[LINK] = link_data;
                m_busy[LINK] = 1'b0;
            end
            if (issue && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        check("cmp_rdata1",  rdata1,  exp_rdata(raddr1));
        check("cmp_rdata2",  rdata2,  exp_rdata(raddr2));
        check("cmp_busy1",   busy1,   exp_busy(raddr1));
        check("cmp_busy2",   busy2,   exp_busy(raddr2));
        check("cmp_stall",   stall,   exp_busy(raddr1) | exp_busy(raddr2));
        check("cmp_pending", pending, 64'($countones(m_busy)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; link = 1'b0; issue = 1'b0;
    endtask

    initial begin
        #12;
        rst = 1'b0;
        tick();

        // Reset state across every index.
        for (int i = 0; i < 32; i++) begin
            raddr1 = ADDR_W'(i);
            raddr2 = ADDR_W'(31 - i);
            #1;
            check("rst_rdata1", rdata1, 0);
            check("rst_rdata2", rdata2, 0);
            check("rst_busy", {busy1, busy2, stall}, 0);
            check("rst_pending", pending, 0);
        end

        // Issue to 5, then resolve it with a write.
        issue = 1'b1; issue_addr = 5;
        tick();
        idle();
        raddr1 = 5; raddr2 = 0;
        #1;
        check("iss5_busy1", busy1, 1);
        check("iss5_stall", stall, 1);
        check("iss5_pending", pending, 1);
        we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        check("wr5_fwd_rdata1", rdata1, 32'hDEADBEEF);
        check("wr5_fwd_busy1", busy1, 0);
`else
        check("wr5_nofwd_rdata1", rdata1, 0);
        check("wr5_nofwd_busy1", busy1, 1);
`endif
        tick();
        idle();
        #1;
        check("wr5_rdata1", rdata1, 32'hDEADBEEF);
        check("wr5_busy1", busy1, 0);
        check("wr5_pending", pending, 0);

        // Link beats we on LINK_REG; writes to 0 are ignored.
        we = 1'b1; waddr = 31; wdata = 32'h11; link = 1'b1; link_data = 32'h400;
        tick();
        idle();
        raddr1 = 31;
        #1;
        check("link_prio", rdata1, 32'h400);
        we = 1'b1; waddr = 0; wdata = 32'hFFFF;
        raddr2 = 0;
        tick();
        idle();
        #1;
        check("reg0_zero", rdata2, 0);
        check("reg0_link_kept", rdata1, 32'h400);

        // Write and issue to the same busy index: busy stays set.
        issue = 1'b1; issue_addr = 7;
        tick();
        idle();
        #1;
        check("iss7_pending", pending, 1);
        issue = 1'b1; issue_addr = 7; we = 1'b1; waddr = 7; wdata = 32'h77;
        tick();
        idle();
        raddr2 = 7;
        #1;
        check("wi7_busy2", busy2, 1);
        check("wi7_pending", pending, 1);
        check("wi7_rdata2", rdata2, 32'h77);
        we = 1'b1; waddr = 7; wdata = 32'h78;
        tick();
        idle();
        #1;
        check("clr7_pending", pending, 0);

        // Issue 3, 4, 0 then an asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            issue = 1'b1; issue_addr = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd0;
            tick();
        end
        idle();
        raddr1 = 3; raddr2 = 4;
        #1;
        check("iss340_pending", pending, 2);
        check("iss340_busy", {busy1, busy2}, 2'b11);
        #1;
        rst = 1'b1;
        #1;
        check("arst_pending", pending, 0);
        check("arst_busy", {busy1, busy2, stall}, 0);
        raddr1 = 5;
        #1;
        check("arst_rdata", rdata1, 0);

        // Writes and issues under reset are discarded.
        we = 1'b1; waddr = 9; wdata = 32'h99; issue = 1'b1; issue_addr = 9; link = 1'b1;
        tick();
        idle();
        #2;
        rst = 1'b0;
        raddr1 = 9; raddr2 = 31;
        #1;
        check("rst_discard_rdata", rdata1, 0);
        check("rst_discard_link", rdata2, 0);
        check("rst_discard_busy", stall, 0);
        tick();

        // Fill the scoreboard to its maximum, then drain through we and link.
        for (int i = 1; i < 32; i++) begin
            issue = 1'b1; issue_addr = ADDR_W'(i);
            tick();
        end
        issue = 1'b1; issue_addr = 12;
        tick();
        idle();
        #1;
        check("pending_max", pending, 31);
        link = 1'b1; link_data = 32'hCAFE0000;
        tick();
        idle();
        #1;
        check("link_clears", pending, 30);
        for (int i = 1; i < 31; i++) begin
            we = 1'b1; waddr = ADDR_W'(i); wdata = 32'h1000 + i;
            raddr1 = ADDR_W'(i); raddr2 = ADDR_W'(i - 1);
            tick();
        end
        we = 1'b1; waddr = 2; wdata = 32'h2222;
        tick();
        idle();
        raddr1 = 30; raddr2 = 2;
        #1;
        check("drain_pending", pending, 0);
        check("drain_rdata1", rdata1, 32'h101E);
        check("drain_rdata2", rdata2, 32'h2222);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
